// File: rtl/mac_acc_unsigned_pkg.sv
// Shared types and defaults for the unsigned multiply-accumulate dot-product block.
package mac_acc_unsigned_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ACC_W = 24;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mac_acc_unsigned_mul.sv
// Combinational unsigned array multiplier: sums the shifted partial products of a, gated by each bit of b.
module mul_unsigned #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] prod_o
);

    logic [2*WIDTH-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b_i[i]) begin
                sum = sum + ((2*WIDTH)'(a_i) << i);
            end
        end
    end

    assign prod_o = sum;

endmodule

// File: rtl/mac_acc_unsigned.sv
// Streaming unsigned dot product: beats flow S1 (operands) -> S2 (product) -> S3 (accumulate);
// a RUN/DRAIN/DONE FSM holds the result until the consumer takes it.
module mac_acc_unsigned
    import mac_acc_unsigned_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf,
    output state_e           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready never depends combinationally on the partner's valid or ready.

    state_e             state_q, state_d;
    logic               first_q, first_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;

    logic               s1_valid_q, s1_last_q, s1_first_q;
    logic [WIDTH-1:0]   s1_a_q, s1_b_q;
    logic               s2_valid_q, s2_last_q, s2_first_q;
    logic [2*WIDTH-1:0] s2_prod_q;

    logic [2*WIDTH-1:0] prod;
    logic [ACC_W:0]     sum;
    logic               accept;

    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign acc_out   = acc_q;
    assign acc_ovf   = ovf_q;
    assign dbg_state = state_q;

    mul_unsigned #(.WIDTH(WIDTH)) u_mul (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .prod_o (prod)
    );

    assign sum = {1'b0, acc_q} + (ACC_W+1)'(s2_prod_q);

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (s2_valid_q && s2_last_q) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        // The beat after reset or after a handoff starts a fresh vector.
        if (accept) first_d = 1'b0;
        if (state_q == ST_DONE && out_ready) first_d = 1'b1;

        if (s2_valid_q) begin
            if (s2_first_q) begin
                acc_d = ACC_W'(s2_prod_q);
                ovf_d = 1'b0;
            end else begin
                acc_d = sum[ACC_W-1:0];
                ovf_d = ovf_q | sum[ACC_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            first_q    <= 1'b1;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_first_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_first_q <= 1'b0;
            s2_prod_q  <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q     <= a;
                s1_b_q     <= b;
                s1_last_q  <= in_last;
                s1_first_q <= first_q;
            end
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_first_q <= s1_first_q;
            s2_prod_q  <= prod;
        end
    end

endmodule

// File: doc/mac_acc_unsigned.md
MAC_ACC_UNSIGNED -- requirements
Module: mac_acc_unsigned

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width of a and b.
REQ-002 SHALL have parameter ACC_W, default 24: accumulator width; ACC_W >= 2*WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand beat valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-007 SHALL have port a, input, WIDTH bits: unsigned multiplicand.
REQ-008 SHALL have port b, input, WIDTH bits: unsigned multiplier.
REQ-009 SHALL have port in_last, input, 1 bit: marks the final beat of a vector.
REQ-010 SHALL have port out_valid, output, 1 bit: dot-product result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port acc_out, output, ACC_W bits: unsigned dot product modulo 2^ACC_W.
REQ-013 SHALL have port acc_ovf, output, 1 bit: sticky flag, set if any accumulation in the vector carried out of ACC_W.

Function
REQ-014 SHALL accept a beat on a rising edge where in_valid and in_ready are both 1; no other edge accepts a beat.
REQ-015 SHALL run a 3-step pipeline: S1 registers a, b and in_last; S2 registers the 2*WIDTH product of the S1 operands; S3 adds the zero-extended S2 product into the accumulator.
REQ-016 SHALL load the accumulator with the product instead of adding when the beat is the first of a vector; the first beat is the first beat accepted after reset or after a result handoff.
REQ-017 SHALL wrap the sum modulo 2^ACC_W and set acc_ovf when any add carries out; acc_ovf clears with the accumulator at the first beat of the next vector.
REQ-018 SHALL implement FSM states RUN, DRAIN and DONE.
REQ-019 SHALL transition RUN->DRAIN on the edge that accepts an in_last beat.
REQ-020 SHALL transition DRAIN->DONE on the edge where S3 consumes that last beat.
REQ-021 SHALL transition DONE->RUN on the edge where out_valid and out_ready are both 1.
REQ-022 SHALL drive in_ready = 1 only in RUN, and decode it from registered state only; in_ready SHALL NOT depend combinationally on out_ready.
REQ-023 SHALL drive out_valid = 1 only in DONE; acc_out and acc_ovf SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL assert out_valid after the 3rd rising edge, counting the edge that accepts the last beat as the 1st.
REQ-025 SHALL insert bubbles for cycles with in_valid = 0 in RUN without altering the accumulator.
REQ-026 SHALL produce acc_out = a*b for a single-beat vector (in_last on the first beat).
REQ-027 SHALL keep in_ready = 0 during the handoff cycle; the next vector's first beat is accepted no earlier than the following edge.

Reset
REQ-028 SHALL, while rst = 1, force state = RUN, all pipeline valids = 0, accumulator = 0, acc_ovf = 0, out_valid = 0, in_ready = 1.
REQ-029 SHALL discard in-flight beats and any held result on reset mid-vector; the first beat after reset starts a new vector.

Structure
REQ-030 SHALL place the FSM state encodings and the default WIDTH/ACC_W values in the shared package.
REQ-031 SHALL instantiate the team's combinational unsigned array multiplier as sub-module mul_unsigned for the S2 product, with no other sub-modules.

Verification
REQ-032 SHALL cover a single beat a=255, b=255, in_last=1: out_valid after the 3rd edge, acc_out=65025, acc_ovf=0.
REQ-033 SHALL cover beats (1,2),(3,4),(5,6),(7,8+last) with in_valid gaps between them: acc_out=100, and in_ready=0 from the last-accept edge until after handoff.
REQ-034 SHALL cover a build with ACC_W=16 and beats (255,255),(255,255+last): acc_out=64514, acc_ovf=1; the following vector (2,3+last) gives 6 with acc_ovf=0.
REQ-035 SHALL cover holding out_ready=0 for 5 cycles in DONE: acc_out is held stable and in_ready stays 0; on release the handoff occurs, and a new vector (4,4+last) starts from 0 and gives 16.
REQ-036 SHALL cover asserting rst while two beats are in S1/S2: all outputs take reset values, and the next vector (3,5+last) gives 15.
